// File: rtl/npu_processor_top.sv
// Single-neuron NPU: dot product of two backdoor-loaded RAMs, plus bias and ReLU, clipped to signed DATA_W.
// One run per reset release; the result is then held until the next reset.

module npu_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [AW-1:0]            addr,
  output logic signed [DATA_W-1:0] rdata
);

  // Contents are loaded only by hierarchical access from outside.
  logic signed [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (rd_en) rdata <= mem[addr];
  end

endmodule

module npu_processor_top #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int N_TAPS = 3,
  parameter int BIAS   = 5,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] result_out,
  output logic              result_valid
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_TAPS - 1);
  localparam logic signed [ACC_W-1:0] BIAS_EXT = ACC_W'(BIAS);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (DATA_W - 1)) - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_BIAS,
    ST_ACT,
    ST_DONE
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0]         idx;
  logic                     rd_en, rd_valid, clr_acc, add_bias, do_act;
  logic signed [DATA_W-1:0] feat_q, weight_q;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc, act_val;

  npu_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(IDX_W)) u_ram_feat (
    .clk   (clk),
    .rd_en (rd_en),
    .addr  (idx),
    .rdata (feat_q)
  );

  npu_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(IDX_W)) u_ram_weight (
    .clk   (clk),
    .rd_en (rd_en),
    .addr  (idx),
    .rdata (weight_q)
  );

  always_ff @(posedge clk) begin
    if (rst_n) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = ST_RUN;
      ST_RUN:   if (idx == LAST_IDX) state_nx = ST_DRAIN;
      ST_DRAIN: state_nx = ST_BIAS;
      ST_BIAS:  state_nx = ST_ACT;
      ST_ACT:   state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en    = (state == ST_RUN);
    clr_acc  = (state == ST_IDLE);
    add_bias = (state == ST_BIAS);
    do_act   = (state == ST_ACT);
  end

  assign prod = feat_q * weight_q;

  always_comb begin
    act_val = acc;
    if (acc < 0)            act_val = '0;
    else if (acc > SAT_MAX) act_val = SAT_MAX;
  end

  // rd_valid trails rd_en by one cycle to line up with the registered RAM output,
  // so the final product lands in DRAIN.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc          <= '0;
      idx          <= '0;
      rd_valid     <= 1'b0;
      result_out   <= '0;
      result_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (clr_acc) begin
        acc <= '0;
        idx <= '0;
      end else begin
        if (rd_en) idx <= idx + 1'b1;
        if (rd_valid)      acc <= acc + ACC_W'(prod);
        else if (add_bias) acc <= acc + BIAS_EXT;
      end
      if (do_act) begin
        result_out   <= act_val[DATA_W-1:0];
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_npu_processor_top.sv
// Bench for npu_processor_top: backdoor-loads both RAMs, runs one inference per reset
// release, and checks latency and result against an arithmetic model.

module tb_npu_processor_top;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int N_TAPS = 3;
  localparam int BIAS   = 5;
  localparam int ACC_W  = 20;
  localparam int LAT    = N_TAPS + 4;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] result_out;
  logic              result_valid;

  int n_total;
  int n_bad;
  int feat_m   [DEPTH];
  int weight_m [DEPTH];

  npu_processor_top #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .N_TAPS (N_TAPS),
    .BIAS   (BIAS),
    .ACC_W  (ACC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .result_out   (result_out),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_result();
    int sum;
    int hi;
    sum = BIAS;
    for (int i = 0; i < N_TAPS; i++) sum += feat_m[i] * weight_m[i];
    hi = (1 << (DATA_W - 1)) - 1;
    if (sum < 0)  return 0;
    if (sum > hi) return hi;
    return sum;
  endfunction

  task automatic load_rams();
    for (int i = 0; i < DEPTH; i++) begin
      dut.u_ram_feat.mem[i]   = DATA_W'(feat_m[i]);
      dut.u_ram_weight.mem[i] = DATA_W'(weight_m[i]);
    end
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int i = 0; i < DEPTH; i++) begin
      feat_m[i]   = lo + int'($urandom_range(0, hi - lo));
      weight_m[i] = lo + int'($urandom_range(0, hi - lo));
    end
  endtask

  task automatic set_taps(input int f0, input int f1, input int f2,
                          input int w0, input int w1, input int w2);
    // Words past the last tap get large junk so a read beyond N_TAPS-1 shows up.
    for (int i = 0; i < DEPTH; i++) begin
      feat_m[i]   = 99;
      weight_m[i] = 77;
    end
    feat_m[0] = f0; feat_m[1] = f1; feat_m[2] = f2;
    weight_m[0] = w0; weight_m[1] = w1; weight_m[2] = w2;
  endtask

  task automatic hold_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".rst_valid"}, int'(result_valid), 0);
    check({tag, ".rst_result"}, int'(result_out), 0);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Counts edges after release until result_valid rises, bounded.
  task automatic wait_valid(output int edges);
    edges = 0;
    for (int e = 1; e <= LAT + 10; e++) begin
      @(posedge clk);
      #1;
      if (result_valid) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic run_case(input string tag);
    int edges;
    int exp;
    exp = model_result();
    load_rams();
    hold_reset(tag);
    wait_valid(edges);
    check({tag, ".latency"}, edges, LAT);
    check({tag, ".result"}, int'(result_out), exp);
    repeat (4) @(posedge clk);
    #1;
    check({tag, ".hold_valid"}, int'(result_valid), 1);
    check({tag, ".hold_result"}, int'(result_out), exp);
  endtask

  initial begin
    int edges;
    int exp;
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b1;
    repeat (2) @(posedge clk);

    set_taps(10, 5, 2, 2, -3, 4);      run_case("basic");
    set_taps(-10, 5, 2, 2, 3, 1);      run_case("mixed");
    set_taps(-100, 0, 0, 100, 0, 0);   run_case("relu");
    set_taps(127, 127, 127, 127, 127, 127); run_case("clip");
    set_taps(0, 0, 0, 0, 0, 0);        run_case("zero");
    set_taps(-128, -128, 0, -128, 1, 0); run_case("minneg");

    for (int t = 0; t < 4; t++) begin
      fill_random(-128, 127);
      run_case($sformatf("rand%0d", t));
    end
    for (int t = 0; t < 3; t++) begin
      fill_random(-12, 12);
      run_case($sformatf("small%0d", t));
    end

    // Reset during RUN, then verify a complete fresh run.
    set_taps(10, 5, 2, 2, -3, 4);
    exp = model_result();
    load_rams();
    hold_reset("abort");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort.valid_in_rst", int'(result_valid), 0);
    check("abort.result_in_rst", int'(result_out), 0);
    @(negedge clk);
    rst_n = 1'b0;
    wait_valid(edges);
    check("abort.latency", edges, LAT);
    check("abort.result", int'(result_out), exp);

    // RAM contents must survive reset: rerun without reloading.
    hold_reset("keep");
    wait_valid(edges);
    check("keep.latency", edges, LAT);
    check("keep.result", int'(result_out), exp);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
